// File: rtl/activation_unit.sv
// activation_unit: Q8.8 sigmoid using the PLAN piecewise-linear approximation.
// A fixed six-state sequence evaluates one sample at a time and then
// re-samples `in` straight away. Each result is published with a one-cycle
// `ready` strobe, and `out` holds that result until the next strobe.
module activation_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in,
   output logic        ready,
   output logic [15:0] out
);

   typedef enum logic [2:0] {LOAD, ABS, SEG, ADD, SIGN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] x_r;
   logic        neg;
   logic [15:0] a_r;
   logic [15:0] term;
   logic [15:0] offset;
   logic [15:0] y;

   // State register. Reset abandons any evaluation that is in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= LOAD;
      else      state_q <= state_d;
   end

   // Fixed ring of states. Every state lasts exactly one cycle.
   always_comb begin
      state_d = LOAD;
      case (state_q)
         LOAD:    state_d = ABS;
         ABS:     state_d = SEG;
         SEG:     state_d = ADD;
         ADD:     state_d = SIGN;
         SIGN:    state_d = DONE;
         DONE:    state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Datapath. Each state performs its step on the clock edge that ends it.
   // The result is published on the edge that completes DONE, so `ready`
   // is high for one cycle in every six.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_r    <= '0;
         neg    <= 1'b0;
         a_r    <= '0;
         term   <= '0;
         offset <= '0;
         y      <= '0;
         out    <= '0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state_q)
            LOAD: begin
               x_r <= in;
               neg <= in[15];
            end
            ABS: begin
               // The negation of -32768 does not fit in 16 bits, so that
               // value saturates to the largest positive magnitude.
               if (x_r == 16'h8000) a_r <= 16'h7FFF;
               else if (x_r[15])    a_r <= -x_r;
               else                 a_r <= x_r;
            end
            SEG: begin
               // The saturated segment is expressed as term = 1.0 with no
               // offset, so ADD does not need a special case for it.
               if (a_r >= 16'h0500) begin
                  term   <= 16'h0100;
                  offset <= 16'h0000;
               end else if (a_r >= 16'h0260) begin
                  term   <= a_r >> 5;
                  offset <= 16'h00D8;
               end else if (a_r >= 16'h0100) begin
                  term   <= a_r >> 3;
                  offset <= 16'h00A0;
               end else begin
                  term   <= a_r >> 2;
                  offset <= 16'h0080;
               end
            end
            ADD: begin
               y <= term + offset;
            end
            SIGN: begin
               // For negative inputs use the identity sigmoid(-x) = 1 - sigmoid(x).
               if (neg) y <= 16'h0100 - y;
            end
            DONE: begin
               out   <= y;
               ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_activation_unit.sv
// Randomized and directed bench for activation_unit. A plain-arithmetic
// sigmoid model predicts each result. Cycle phases are counted from the
// release of reset.
module tb_activation_unit;

   logic        clk;
   logic        rst;
   logic [15:0] in;
   logic        ready;
   logic [15:0] out;

   int          n_vec;
   int          n_err;
   logic [15:0] last;

   activation_unit dut (
      .clk   (clk),
      .rst   (rst),
      .in    (in),
      .ready (ready),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_sig(input logic [15:0] x);
      int v;
      int a;
      int y;
      v = int'($signed(x));
      a = (v < 0) ? -v : v;
      if (a > 32767) a = 32767;
      if (a >= 1280)     y = 256;
      else if (a >= 608) y = a / 32 + 216;
      else if (a >= 256) y = a / 8 + 160;
      else               y = a / 4 + 128;
      if (v < 0) y = 256 - y;
      return 16'(y);
   endfunction

   // One full evaluation window, entered at a negedge just before the LOAD
   // edge. `v` is presented only for the LOAD edge. On the other five edges
   // `in` carries junk: a random value when g < 0, otherwise g.
   task automatic run_win(input logic [15:0] v, input int g);
      logic [15:0] exp;
      exp = ref_sig(v);
      for (int p = 0; p < 6; p++) begin
         if (p == 0)    in = v;
         else if (g < 0) in = 16'($urandom);
         else           in = 16'(g);
         @(posedge clk);
         @(negedge clk);
         if (p == 5) begin
            chk("ready_pulse", {15'b0, ready}, 16'h0001);
            chk("out_result", out, exp);
            last = exp;
         end else begin
            chk("ready_low", {15'b0, ready}, 16'h0000);
            chk("out_hold", out, last);
         end
      end
   endtask

   // Start an evaluation and reset it part-way through. Reset must clear
   // `out` and `ready` before the next clock edge.
   task automatic mid_reset(input logic [15:0] v);
      for (int p = 0; p < 3; p++) begin
         in = (p == 0) ? v : 16'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("ready_low", {15'b0, ready}, 16'h0000);
         chk("out_hold", out, last);
      end
      #2 rst = 1'b0;
      #1;
      chk("async_rst_out", out, 16'h0000);
      chk("async_rst_ready", {15'b0, ready}, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_out", out, 16'h0000);
      chk("rst_hold_ready", {15'b0, ready}, 16'h0000);
      last = 16'h0000;
      rst  = 1'b1;
   endtask

   logic [15:0] dir_v [13] = '{16'h0280, 16'h0280, 16'h0280,
                               16'h0000, 16'h00FF, 16'h0100, 16'h0260,
                               16'h0500, 16'h7FFF, 16'hFD80, 16'hFF00,
                               16'h8000, 16'h04FF};

   initial begin
      n_vec = 0;
      n_err = 0;
      last  = 16'h0000;
      rst   = 1'b0;
      in    = 16'h0280;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", out, 16'h0000);
      chk("reset_ready", {15'b0, ready}, 16'h0000);

      // Release reset. The next rising edge is the first LOAD edge.
      rst = 1'b1;
      // The first three windows hold +2.5 steady (the nominal 0xEC pulse).
      // The remaining windows walk the segment boundaries and negative inputs.
      for (int i = 0; i < 13; i++) run_win(dir_v[i], (i < 3) ? 16'h0280 : -1);

      // Change `in` the cycle after LOAD. The evaluation in progress must
      // ignore the change, and the following window picks up the new value.
      run_win(16'h0280, 16'hFD80);
      run_win(16'hFD80, 16'hFD80);

      mid_reset(16'hFD80);
      run_win(16'h0280, -1);

      for (int i = 0; i < 40; i++) run_win(16'($urandom), -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
